ct_rr_arbiter: RTL and testbench
================================

Name: ct_rr_arbiter

Overview:
- Packet-aware round-robin arbiter that shares one downstream field-conversion/transport stage among NI ready/valid source streams.
- Each source presents data, a field (address/tag), and an end-of-packet flag. The arbiter grants one source at a time and holds the grant until that source's EOP beat is accepted.
- Forwards beats through a single registered output stage and tags each beat with the granted source index. Sits directly upstream of the field-conversion stage.

Parameters:
- NI, 2, number of requesting input streams (>=2)
- WD, 8, passthrough data width per input (excludes field)
- WF, 4, field width per input
- WS, $clog2(NI), width of o_src (derived; not overridden)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- i_data  input  NI*WD  input k data at [WD*k +: WD]
- i_field  input  NI*WF  input k field at [WF*k +: WF]
- i_eop  input  NI  input k end-of-packet flag
- i_valid  input  NI  input k valid
- o_ready  output  NI  input k ready
- o_data  output  WD  forwarded data
- o_field  output  WF  forwarded field
- o_eop  output  1  forwarded EOP
- o_src  output  WS  index of the source of the current output beat
- o_valid  output  1  output valid
- i_ready  input  1  downstream ready

Behaviour:
- Reset (async assert, released synchronously to clk):
  - o_valid=0; o_data, o_field, o_eop, o_src=0.
  - State=IDLE; last-grant pointer ptr=NI-1, so input 0 has first priority.
- Output register:
  - `adv = ~o_valid | i_ready`.
  - When adv=1, the register loads the selected beat (o_valid=1) or clears to o_valid=0 if no beat is selected.
  - When adv=0, the register holds all outputs stable; no output changes while o_valid=1 and i_ready=0.
- Latency: 1 cycle from input accept to o_valid. Throughput: 1 beat/cycle with i_ready held high.
- Accept: input k's beat is accepted iff `o_ready[k] & i_valid[k]`.
  - `o_ready[k] = adv & (sel==k) & sel_valid`. At most one o_ready bit is high per cycle.
  - o_ready is combinational from i_valid, state, and i_ready. There is no combinational path from i_valid[k] to o_ready[j≠k] except through the arbitration choice.
- State machine:
  - IDLE:
    - sel = first k with i_valid[k]=1, scanning ptr+1, ptr+2, … modulo NI (wrap-around).
    - sel_valid = |i_valid.
    - On accept with i_eop[sel]=1 (single-beat packet): ptr<=sel; stay IDLE.
    - On accept with i_eop[sel]=0: lock<=sel; go to LOCKED.
  - LOCKED:
    - sel = lock; sel_valid = i_valid[lock]. Other inputs are never granted, even if the locked input idles (bubbles are allowed).
    - On accept with i_eop[lock]=1: ptr<=lock; go to IDLE.
- Fairness: after a packet from input k completes, priority starts at k+1. An input with continuously pending packets waits at most NI-1 packets.
- Simultaneous events:
  - A new arbitration decision takes effect in the same cycle that IDLE is entered; the next packet's first beat can be accepted in the cycle after the EOP beat.
  - An IDLE-cycle decision is made only when adv=1; if adv=0, no grant and no ptr change.
- Reset mid-packet: the lock and the output beat are discarded, state returns to IDLE with ptr=NI-1. Sources must restart their packets.
- Sources must hold data, field, and eop stable while valid and not accepted. The arbiter never drops or duplicates a beat.
- Simulation assertions:
  - $onehot0(o_ready).
  - o_valid held and outputs stable while ~i_ready.
  - ptr<NI.

Test Plan:
- Reset/idle: NI=3, WD=8, WF=2; assert reset with all i_valid=0 -> o_valid=0 and o_ready=3'b000 every cycle; o_src=0.
- Single-beat rotation: all three inputs continuously valid with eop=1, data=8'hA0+k, i_ready=1 -> o_src sequence 0,1,2,0,1,2; o_data A0,A1,A2,…; o_valid high every cycle after the first.
- Packet lock: input 1 sends 3 beats (eop on beat 3) while input 0 is valid with eop=1 -> o_src=1,1,1 then 0; input 0's o_ready stays 0 during the lock. Insert an input-1 bubble mid-packet -> o_valid drops for one cycle and input 0 is still not granted.
- Backpressure: during stream, i_ready=0 for 4 cycles -> o_data, o_field, o_eop, and o_src frozen; o_ready all 0; resume -> no beat lost or duplicated (compare against a scoreboard of 20 random beats).
- Wrap/fairness: ptr=2 (last grant to input 2), inputs 0 and 2 both valid -> input 0 granted first, then 2.
- Async reset mid-packet: assert reset between clock edges during input-2's beat 2 of 4 -> o_valid=0 immediately. After release, input 0 (valid) is granted before input 2.

Source files
------------

// File: rtl/ct_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ct_rr_arbiter
//
// Packet-aware round-robin arbiter. NI ready/valid source streams share one
// downstream field-conversion stage. A source that wins arbitration keeps the
// grant until its end-of-packet beat is accepted. Beats leave through a single
// registered output stage, and each beat is tagged with its source index.
//
// States
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | no packet in flight; round-robin pick starting after ptr
//   LOCKED | a multi-beat packet from source lock_q is in progress
//
// Ports
//   clk      : clock
//   reset    : asynchronous, active-high reset
//   i_data   : NI x WD source data, source k at [WD*k +: WD]
//   i_field  : NI x WF source field (address/tag), source k at [WF*k +: WF]
//   i_eop    : per-source end-of-packet flag
//   i_valid  : per-source valid
//   o_ready  : per-source ready (at most one bit high)
//   o_data   : forwarded data
//   o_field  : forwarded field
//   o_eop    : forwarded end-of-packet
//   o_src    : source index of the current output beat
//   o_valid  : output valid
//   i_ready  : downstream ready
// ---------------------------------------------------------------------------
module ct_rr_arbiter #(
  parameter  int NI = 2,
  parameter  int WD = 8,
  parameter  int WF = 4,
  localparam int WS = (NI > 1) ? $clog2(NI) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NI*WD-1:0] i_data,
  input  logic [NI*WF-1:0] i_field,
  input  logic [NI-1:0]    i_eop,
  input  logic [NI-1:0]    i_valid,
  output logic [NI-1:0]    o_ready,
  output logic [WD-1:0]    o_data,
  output logic [WF-1:0]    o_field,
  output logic             o_eop,
  output logic [WS-1:0]    o_src,
  output logic             o_valid,
  input  logic             i_ready
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [WS-1:0]   ptr_q, ptr_d;
  logic [WS-1:0]   lock_q, lock_d;

  logic            valid_q, valid_d;
  logic [WD-1:0]   data_q, data_d;
  logic [WF-1:0]   field_q, field_d;
  logic            eop_q, eop_d;
  logic [WS-1:0]   src_q, src_d;

  logic            adv;
  logic [WS-1:0]   rr_sel;
  logic [WS-1:0]   rr_cand;
  logic            rr_found;
  logic [WS-1:0]   sel;
  logic            sel_valid;
  logic            sel_eop;
  logic            accept;

  // -------------------------------------------------------------------------
  // Round-robin pick: first valid source scanning ptr+1, ptr+2, ... mod NI.
  // The scan ends on ptr itself, so the last-granted source has lowest
  // priority.
  // -------------------------------------------------------------------------
  always_comb begin
    rr_sel   = '0;
    rr_cand  = '0;
    rr_found = 1'b0;
    for (int i = 1; i <= NI; i++) begin
      rr_cand = WS'((int'(ptr_q) + i) % NI);
      if (!rr_found && i_valid[rr_cand]) begin
        rr_sel   = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Grant, handshake and next-state logic.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;

    adv = ~valid_q | i_ready;

    if (state_q == LOCKED) begin
      // Bubbles on the locked source stall the output; nobody else may cut in.
      sel       = lock_q;
      sel_valid = i_valid[lock_q];
    end else begin
      sel       = rr_sel;
      sel_valid = |i_valid;
    end

    // Ready is held off while reset is asserted so that no source believes a
    // beat was taken while the output stage is being cleared.
    o_ready = '0;
    if (adv && sel_valid && !reset) begin
      o_ready[sel] = 1'b1;
    end

    accept  = |(o_ready & i_valid);
    sel_eop = i_eop[sel];

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (sel_eop) begin
            ptr_d = sel;
          end else begin
            lock_d  = sel;
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (accept && sel_eop) begin
          ptr_d   = lock_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output register. It only moves when the downstream can take a beat or
  // the register is empty; payload holds when no new beat is loaded.
  // -------------------------------------------------------------------------
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    field_d = field_q;
    eop_d   = eop_q;
    src_d   = src_q;
    if (adv) begin
      valid_d = accept;
      if (accept) begin
        data_d  = i_data[WD*sel +: WD];
        field_d = i_field[WF*sel +: WF];
        eop_d   = sel_eop;
        src_d   = sel;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= WS'(NI - 1);
      lock_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      field_q <= '0;
      eop_q   <= 1'b0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      field_q <= field_d;
      eop_q   <= eop_d;
      src_q   <= src_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_field = field_q;
  assign o_eop   = eop_q;
  assign o_src   = src_q;

  // -------------------------------------------------------------------------
  // Simulation checks.
  // -------------------------------------------------------------------------
  a_ready_onehot0 : assert property (@(posedge clk) disable iff (reset)
    $onehot0(o_ready));

  a_hold_stable : assert property (@(posedge clk) disable iff (reset)
    (valid_q && !i_ready) |=> (valid_q && $stable({data_q, field_q, eop_q, src_q})));

  a_ptr_range : assert property (@(posedge clk) disable iff (reset)
    (int'(ptr_q) < NI) && (int'(lock_q) < NI));

endmodule

// File: tb/tb_ct_rr_arbiter.sv
module tb_ct_rr_arbiter;

  localparam int NI = 3;
  localparam int WD = 8;
  localparam int WF = 2;
  localparam int WS = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NI*WD-1:0] i_data;
  logic [NI*WF-1:0] i_field;
  logic [NI-1:0]    i_eop;
  logic [NI-1:0]    i_valid;
  logic [NI-1:0]    o_ready;
  logic [WD-1:0]    o_data;
  logic [WF-1:0]    o_field;
  logic             o_eop;
  logic [WS-1:0]    o_src;
  logic             o_valid;
  logic             i_ready;

  typedef struct packed {
    logic [WS-1:0] src;
    logic          eop;
    logic [WF-1:0] field;
    logic [WD-1:0] data;
  } beat_t;

  int    n_cmp = 0;
  int    n_err = 0;
  beat_t exp_q[$];

  logic [WD-1:0] bp_d [20];
  logic [WF-1:0] bp_f [20];
  logic          bp_e [20];

  ct_rr_arbiter #(.NI(NI), .WD(WD), .WF(WF)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_data  (i_data),
    .i_field (i_field),
    .i_eop   (i_eop),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_field (o_field),
    .o_eop   (o_eop),
    .o_src   (o_src),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [WS-1:0] s, input logic [WD-1:0] d,
                         input logic [WF-1:0] f, input logic e);
    beat_t b;
    b = '{src: s, eop: e, field: f, data: d};
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_beat"}, 32'({o_src, o_eop, o_field, o_data}), 32'(b));
  endtask

  task automatic drive(input int k, input logic v, input logic [WD-1:0] d,
                       input logic [WF-1:0] f, input logic e);
    i_valid[k]          = v;
    i_data[WD*k +: WD]  = d;
    i_field[WF*k +: WF] = f;
    i_eop[k]            = e;
  endtask

  initial begin
    int idx;
    int cyc;

    reset   = 1'b1;
    i_valid = '0;
    i_data  = '0;
    i_field = '0;
    i_eop   = '0;
    i_ready = 1'b1;

    // Reset / idle
    #2;
    chk("rst_valid0", 32'(o_valid), 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_ready", 32'(o_ready), 32'd0);
      chk("rst_src", 32'(o_src), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    #1 chk("idle_ready", 32'(o_ready), 32'd0);
    @(negedge clk);
    chk("idle_valid", 32'(o_valid), 32'd0);

    // Single-beat rotation: 0,1,2,0,1,2
    for (int k = 0; k < NI; k++) drive(k, 1'b1, 8'hA0 + 8'(k), WF'(k), 1'b1);
    #1 chk("rot_ready0", 32'(o_ready), 32'b001);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk_out("rot", WS'((c - 1) % 3), 8'hA0 + 8'((c - 1) % 3), WF'((c - 1) % 3), 1'b1);
      if (c < 6) chk("rot_ready", 32'(o_ready), 32'(1 << (c % 3)));
    end
    i_valid = '0;
    @(negedge clk);
    chk("rot_drain", 32'(o_valid), 32'd0);

    // Wrap: ptr=2, inputs 0 and 2 valid -> 0 then 2
    drive(0, 1'b1, 8'hB0, 2'd0, 1'b1);
    drive(2, 1'b1, 8'hB2, 2'd2, 1'b1);
    #1 chk("wrap_ready0", 32'(o_ready), 32'b001);
    @(negedge clk);
    chk_out("wrap0", 2'd0, 8'hB0, 2'd0, 1'b1);
    chk("wrap_ready2", 32'(o_ready), 32'b100);
    @(negedge clk);
    chk_out("wrap2", 2'd2, 8'hB2, 2'd2, 1'b1);
    i_valid = '0;
    @(negedge clk);
    chk("wrap_drain", 32'(o_valid), 32'd0);

    // Packet lock: move ptr to 0, then input 1 sends 3 beats with a bubble
    drive(0, 1'b1, 8'hC0, 2'd0, 1'b1);
    #1 chk("lock_pre_ready", 32'(o_ready), 32'b001);
    @(negedge clk);
    chk_out("lock_pre", 2'd0, 8'hC0, 2'd0, 1'b1);
    drive(0, 1'b1, 8'hD0, 2'd0, 1'b1);
    drive(1, 1'b1, 8'hE1, 2'd1, 1'b0);
    #1 chk("lock_grant", 32'(o_ready), 32'b010);
    @(negedge clk);
    chk_out("lock_b1", 2'd1, 8'hE1, 2'd1, 1'b0);
    drive(1, 1'b0, 8'hE1, 2'd1, 1'b0);
    #1 chk("lock_bubble_ready", 32'(o_ready), 32'b000);
    @(negedge clk);
    chk("lock_bubble_valid", 32'(o_valid), 32'd0);
    drive(1, 1'b1, 8'hE2, 2'd1, 1'b0);
    #1 chk("lock_b2_ready", 32'(o_ready), 32'b010);
    @(negedge clk);
    chk_out("lock_b2", 2'd1, 8'hE2, 2'd1, 1'b0);
    drive(1, 1'b1, 8'hE3, 2'd1, 1'b1);
    #1 chk("lock_b3_ready", 32'(o_ready), 32'b010);
    @(negedge clk);
    chk_out("lock_b3", 2'd1, 8'hE3, 2'd1, 1'b1);
    drive(1, 1'b0, 8'hE3, 2'd1, 1'b1);
    #1 chk("lock_release_ready", 32'(o_ready), 32'b001);
    @(negedge clk);
    chk_out("lock_after", 2'd0, 8'hD0, 2'd0, 1'b1);
    i_valid = '0;
    @(negedge clk);
    chk("lock_drain", 32'(o_valid), 32'd0);

    // Backpressure: 20 random beats from input 2 against a scoreboard
    for (int n = 0; n < 20; n++) begin
      bp_d[n] = 8'($urandom);
      bp_f[n] = 2'($urandom);
      bp_e[n] = (n == 19) ? 1'b1 : 1'($urandom);
    end
    idx = 0;
    cyc = 0;
    while ((idx < 20 || exp_q.size() > 0) && cyc < 100) begin
      @(negedge clk);
      i_ready = !((cyc >= 4 && cyc <= 7) || cyc == 12);
      if (idx < 20) drive(2, 1'b1, bp_d[idx], bp_f[idx], bp_e[idx]);
      else i_valid[2] = 1'b0;
      #1;
      if (exp_q.size() > 0) begin
        chk("bp_valid", 32'(o_valid), 32'd1);
        chk("bp_beat", 32'({o_src, o_eop, o_field, o_data}), 32'(exp_q[0]));
        if (!i_ready) chk("bp_stall_ready", 32'(o_ready), 32'd0);
        else void'(exp_q.pop_front());
      end else begin
        chk("bp_empty", 32'(o_valid), 32'd0);
      end
      if (o_ready[2] && i_valid[2]) begin
        exp_q.push_back('{src: 2'd2, eop: bp_e[idx], field: bp_f[idx], data: bp_d[idx]});
        idx++;
      end
      cyc++;
    end
    chk("bp_sent", 32'(idx), 32'd20);
    chk("bp_left", 32'(exp_q.size()), 32'd0);
    i_ready = 1'b1;
    i_valid = '0;
    @(negedge clk);
    chk("bp_drain", 32'(o_valid), 32'd0);

    // Async reset mid-packet (ptr=2 after the backpressure packet)
    drive(2, 1'b1, 8'hF1, 2'd3, 1'b0);
    #1 chk("ar_ready_b1", 32'(o_ready), 32'b100);
    @(negedge clk);
    chk_out("ar_b1", 2'd2, 8'hF1, 2'd3, 1'b0);
    drive(2, 1'b1, 8'hF2, 2'd3, 1'b0);
    drive(0, 1'b1, 8'h60, 2'd0, 1'b1);
    #1 chk("ar_locked_ready", 32'(o_ready), 32'b100);
    @(negedge clk);
    chk_out("ar_b2", 2'd2, 8'hF2, 2'd3, 1'b0);
    reset = 1'b1;
    drive(2, 1'b1, 8'hF1, 2'd3, 1'b0);
    #1;
    chk("ar_valid_now", 32'(o_valid), 32'd0);
    chk("ar_ready_rst", 32'(o_ready), 32'd0);
    @(negedge clk);
    chk("ar_valid_hold", 32'(o_valid), 32'd0);
    reset = 1'b0;
    #1 chk("ar_prio_ready", 32'(o_ready), 32'b001);
    @(negedge clk);
    chk_out("ar_first", 2'd0, 8'h60, 2'd0, 1'b1);
    drive(0, 1'b0, 8'h60, 2'd0, 1'b1);
    #1 chk("ar_next_ready", 32'(o_ready), 32'b100);
    @(negedge clk);
    chk_out("ar_restart", 2'd2, 8'hF1, 2'd3, 1'b0);
    i_valid = '0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
